// File: rtl/rs_pkg.sv
// rs_pkg: shared entry type and ROB age helper for the age-ordered reservation station
package rs_pkg;
  localparam int RS_PREG_W = 7;
  localparam int RS_ROB_W = 4;
  typedef struct packed {
    logic valid;
    logic rs1_ready;
    logic rs2_ready;
    logic [RS_PREG_W-1:0] prs1;
    logic [RS_PREG_W-1:0] prs2;
    logic [RS_PREG_W-1:0] prd;
    logic [RS_ROB_W-1:0] rob_tag;
    logic [31:0] imm;
    logic [3:0] alu_op;
    logic [31:0] pc;
    logic alusrc;
    logic memwrite;
  } rs_entry_t;
  function automatic logic [RS_ROB_W-1:0] rob_age(input logic [RS_ROB_W-1:0] tag, input logic [RS_ROB_W-1:0] head);
    return tag - head;
  endfunction
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: picks the candidate with the smallest age via a pairwise min tree
module rs_age_select #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic [N-1:0]        cand,
  input  logic [N-1:0][W-1:0] ages,
  output logic                found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int L = $clog2(N);
  localparam int P = 1 << L;
  logic         v [P];
  logic [W-1:0] a [P];
  logic [L-1:0] x [P];
  always_comb begin
    for (int j = 0; j < P; j++) begin
      v[j] = 1'b0;
      a[j] = '0;
      x[j] = L'(j);
      if (j < N) begin
        v[j] = cand[j];
        a[j] = ages[j];
      end
    end
    for (int s = 1; s < P; s = s * 2)
      for (int j = 0; j + s < P; j = j + 2 * s)
        if (v[j+s] && (!v[j] || a[j+s] < a[j])) begin
          v[j] = 1'b1;
          a[j] = a[j+s];
          x[j] = x[j+s];
        end
    found = v[0];
    idx = x[0];
  end
endmodule

// File: rtl/age_ordered_rs.sv
// age_ordered_rs: multi-CDB reservation station issuing oldest-ready by ROB age with selective flush.
// Optional RS_PERF_CNT_EN adds full-stall and issue performance counters.
module age_ordered_rs import rs_pkg::*; #(
  parameter int PREG_WIDTH = RS_PREG_W,
  parameter int ROB_WIDTH = RS_ROB_W,
  parameter int RS_SIZE = 8,
  parameter int N_CDB = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_valid,
  input  logic [31:0]                 i_pc,
  input  logic [PREG_WIDTH-1:0]       i_prs1,
  input  logic [PREG_WIDTH-1:0]       i_prs2,
  input  logic [PREG_WIDTH-1:0]       i_prd,
  input  logic [ROB_WIDTH-1:0]        i_rob_tag,
  input  logic [31:0]                 i_imm,
  input  logic [3:0]                  i_alu_op,
  input  logic                        i_alusrc,
  input  logic                        i_memwrite,
  input  logic                        i_rs1_ready,
  input  logic                        i_rs2_ready,
  output logic                        o_full,
  output logic [$clog2(RS_SIZE+1)-1:0] o_count,
  input  logic [N_CDB-1:0]            i_cdb_valid,
  input  logic [N_CDB*PREG_WIDTH-1:0] i_cdb_prd,
  input  logic                        i_eu_ready,
  output logic                        o_issue_valid,
  output logic [PREG_WIDTH-1:0]       o_issue_prs1,
  output logic [PREG_WIDTH-1:0]       o_issue_prs2,
  output logic [PREG_WIDTH-1:0]       o_issue_prd,
  output logic [ROB_WIDTH-1:0]        o_issue_rob_tag,
  output logic [31:0]                 o_issue_imm,
  output logic [31:0]                 o_issue_pc,
  output logic [3:0]                  o_issue_alu_op,
  output logic                        o_issue_alusrc,
  output logic                        o_issue_memwrite,
  input  logic [ROB_WIDTH-1:0]        i_rob_head,
  input  logic                        i_flush_valid,
  input  logic [ROB_WIDTH-1:0]        i_flush_rob_tag
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]                 o_perf_full_stall,
  output logic [31:0]                 o_perf_issue_cnt
`endif
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = $clog2(RS_SIZE+1);
  rs_entry_t q [RS_SIZE];
  rs_entry_t d [RS_SIZE];
  logic [RS_SIZE-1:0] cand;
  logic [RS_SIZE-1:0][ROB_WIDTH-1:0] ages;
  logic [ROB_WIDTH-1:0] flush_age;
  logic sel_found, free_found, alloc, fire;
  logic [IW-1:0] sel_idx, free_idx;
  logic [CW-1:0] nxt_count;
  function automatic logic cdb_hit(input logic [N_CDB-1:0] v, input logic [N_CDB*PREG_WIDTH-1:0] p, input logic [PREG_WIDTH-1:0] t);
    cdb_hit = 1'b0;
    for (int k = 0; k < N_CDB; k++)
      cdb_hit = cdb_hit | (v[k] && p[k*PREG_WIDTH +: PREG_WIDTH] == t && t != '0);
  endfunction
  always_comb begin
    free_found = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ages[i] = rob_age(q[i].rob_tag, i_rob_head);
      cand[i] = q[i].valid && q[i].rs1_ready && q[i].rs2_ready;
      if (!q[i].valid) begin
        free_found = 1'b1;
        free_idx = IW'(i);
      end
    end
  end
  rs_age_select #(.N(RS_SIZE), .W(ROB_WIDTH)) u_sel (
    .cand(cand), .ages(ages), .found(sel_found), .idx(sel_idx)
  );
  assign o_full = !free_found;
  assign alloc = i_valid && free_found && !i_flush_valid;
  assign o_issue_valid = sel_found && !i_flush_valid;
  assign fire = o_issue_valid && i_eu_ready;
  assign flush_age = rob_age(i_flush_rob_tag, i_rob_head);
  assign o_issue_prs1 = o_issue_valid ? q[sel_idx].prs1 : '0;
  assign o_issue_prs2 = o_issue_valid ? q[sel_idx].prs2 : '0;
  assign o_issue_prd = o_issue_valid ? q[sel_idx].prd : '0;
  assign o_issue_rob_tag = o_issue_valid ? q[sel_idx].rob_tag : '0;
  assign o_issue_imm = o_issue_valid ? q[sel_idx].imm : '0;
  assign o_issue_pc = o_issue_valid ? q[sel_idx].pc : '0;
  assign o_issue_alu_op = o_issue_valid ? q[sel_idx].alu_op : '0;
  assign o_issue_alusrc = o_issue_valid && q[sel_idx].alusrc;
  assign o_issue_memwrite = o_issue_valid && q[sel_idx].memwrite;
  always_comb begin
    nxt_count = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      d[i] = q[i];
      d[i].rs1_ready = q[i].rs1_ready | cdb_hit(i_cdb_valid, i_cdb_prd, q[i].prs1);
      d[i].rs2_ready = q[i].rs2_ready | cdb_hit(i_cdb_valid, i_cdb_prd, q[i].prs2);
      if ((i_flush_valid && ages[i] > flush_age) || (fire && sel_idx == IW'(i)))
        d[i].valid = 1'b0;
      if (alloc && free_idx == IW'(i)) begin
        d[i].valid = 1'b1;
        d[i].rs1_ready = i_prs1 == '0 || i_rs1_ready || cdb_hit(i_cdb_valid, i_cdb_prd, i_prs1);
        d[i].rs2_ready = i_prs2 == '0 || i_rs2_ready || cdb_hit(i_cdb_valid, i_cdb_prd, i_prs2);
        d[i].prs1 = i_prs1;
        d[i].prs2 = i_prs2;
        d[i].prd = i_prd;
        d[i].rob_tag = i_rob_tag;
        d[i].imm = i_imm;
        d[i].alu_op = i_alu_op;
        d[i].pc = i_pc;
        d[i].alusrc = i_alusrc;
        d[i].memwrite = i_memwrite;
      end
      nxt_count = nxt_count + CW'(d[i].valid);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RS_SIZE; i++) q[i] <= '0;
      o_count <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) q[i] <= d[i];
      o_count <= nxt_count;
    end
  end
`ifdef RS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      o_perf_full_stall <= '0;
      o_perf_issue_cnt <= '0;
    end else begin
      o_perf_full_stall <= o_perf_full_stall + 32'(i_valid && o_full);
      o_perf_issue_cnt <= o_perf_issue_cnt + 32'(fire);
    end
  end
`endif
endmodule
